// File: rtl/add_serial_pkg.sv
// add_serial_pkg
// Shared definitions for the serial add/subtract unit: the controller
// state encoding used by add_sub_serial.
package add_serial_pkg;

    // Controller states. Encoding is fixed so other blocks and debug
    // tooling can decode the 2-bit state value directly.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/add_serial_slice.sv
// add_serial_slice
// Combinational BPC-bit ripple-carry adder, one chunk of the serial datapath.
// Ports:
//   a, b   - BPC-bit operand chunks
//   cin    - carry into bit 0
//   sum    - BPC-bit sum chunk
//   c_msb  - carry into the chunk's top bit (used for signed overflow)
//   cout   - carry out of the chunk's top bit
module add_serial_slice #(
    parameter int BPC = 1
) (
    input  logic [BPC-1:0] a,
    input  logic [BPC-1:0] b,
    input  logic           cin,
    output logic [BPC-1:0] sum,
    output logic           c_msb,
    output logic           cout
);

    logic [BPC:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < BPC; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign c_msb = c[BPC-1];
    assign cout  = c[BPC];

endmodule

// File: rtl/add_sub_serial.sv
// add_sub_serial
// Bit-serial (BPC bits per cycle) adder/subtractor with an IDLE/ADD/DONE
// handshake. Subtraction is a + ~b + 1, so the carry register is seeded
// with sub and b is inverted on load.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   en         - start request (sampled in IDLE); sub/a/b captured with it
//   sub        - 0 = a+b, 1 = a-b
//   a, b       - WIDTH-bit operands
//   ack        - result consumed (sampled in DONE)
//   out        - WIDTH-bit result register
//   cout       - final carry (for sub: 1 = no borrow)
//   ovf        - two's-complement signed overflow
//   busy, done - high in ADD / DONE respectively
module add_sub_serial
    import add_serial_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int BPC   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ack,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int NCHUNK = WIDTH / BPC;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    state_t           state, state_next;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic             carry;
    logic [CW-1:0]    count;
    logic             last;

    logic [BPC-1:0]       sum;
    logic                 c_msb, c_out;
    logic [WIDTH+BPC-1:0] out_cat;

    add_serial_slice #(.BPC(BPC)) u_slice (
        .a     (a_reg[BPC-1:0]),
        .b     (b_reg[BPC-1:0]),
        .cin   (carry),
        .sum   (sum),
        .c_msb (c_msb),
        .cout  (c_out)
    );

    // New chunk enters at the MSB end; after NCHUNK shifts the first chunk
    // has reached bit 0. Concatenation keeps this legal when BPC == WIDTH.
    assign out_cat = {sum, out};
    assign last    = (count == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (en)   state_next = ADD;
            ADD:     if (last) state_next = DONE;
            DONE:    if (ack)  state_next = IDLE;
            default:           state_next = IDLE;
        endcase
    end

    assign busy = (state == ADD);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            carry <= 1'b0;
            count <= '0;
            out   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        a_reg <= a;
                        b_reg <= sub ? ~b : b;
                        carry <= sub;
                        count <= '0;
                        out   <= '0;
                    end
                end
                ADD: begin
                    out   <= out_cat[WIDTH+BPC-1:BPC];
                    a_reg <= a_reg >> BPC;
                    b_reg <= b_reg >> BPC;
                    carry <= c_out;
                    // Flags only change on the final chunk so they stay
                    // stable through DONE; count stops at LAST (no wrap).
                    if (last) begin
                        cout <= c_out;
                        ovf  <= c_msb ^ c_out;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_add_sub_serial.sv
// tb_add_sub_serial
// Self-checking bench: WIDTH=8/BPC=1 instance driven from a vector table
// and scoreboard queue, plus a WIDTH=16/BPC=4 instance for the chunked path.
module tb_add_sub_serial;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       en, sub, ack;
    logic [7:0] a, b, out;
    logic       cout, ovf, busy, done;

    logic        en2, sub2, ack2;
    logic [15:0] a2, b2, out2;
    logic        cout2, ovf2, busy2, done2;

    add_sub_serial #(.WIDTH(8), .BPC(1)) dut (
        .clk(clk), .rst(rst), .en(en), .sub(sub), .a(a), .b(b), .ack(ack),
        .out(out), .cout(cout), .ovf(ovf), .busy(busy), .done(done)
    );

    add_sub_serial #(.WIDTH(16), .BPC(4)) dut16 (
        .clk(clk), .rst(rst), .en(en2), .sub(sub2), .a(a2), .b(b2), .ack(ack2),
        .out(out2), .cout(cout2), .ovf(ovf2), .busy(busy2), .done(done2)
    );

    typedef struct {
        logic       s;
        logic [7:0] x, y;
        logic [7:0] r;
        logic       c, v;
    } vec_t;

    vec_t tbl[10];
    vec_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t model(input logic s, input logic [7:0] x, input logic [7:0] y);
        vec_t       v;
        logic [8:0] full;
        full  = {1'b0, x} + {1'b0, (s ? -y : y)};
        v.s = s; v.x = x; v.y = y;
        v.r = full[7:0];
        // Carry: for add the 9th bit; for sub, 1 means x >= y (no borrow).
        v.c = s ? (x >= y) : full[8];
        v.v = s ? ((x[7] != y[7]) && (v.r[7] != x[7]))
                : ((x[7] == y[7]) && (v.r[7] != x[7]));
        return v;
    endfunction

    task automatic start_op(input logic s, input logic [7:0] x, input logic [7:0] y);
        @(negedge clk);
        en = 1'b1; sub = s; a = x; b = y;
        @(negedge clk);
        en = 1'b0;
    endtask

    // Called at the negedge after the accepting edge; counts ADD cycles.
    task automatic wait_done(output int nbusy, output bit ok);
        nbusy = 0;
        ok    = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (busy) nbusy++;
            @(negedge clk);
        end
    endtask

    task automatic check_result(input string name);
        vec_t e;
        e = q.pop_front();
        chk({name, " out"},  64'(out),  64'(e.r));
        chk({name, " cout"}, 64'(cout), 64'(e.c));
        chk({name, " ovf"},  64'(ovf),  64'(e.v));
    endtask

    task automatic do_ack();
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("idle after ack done", 64'(done), 64'(0));
        chk("idle after ack busy", 64'(busy), 64'(0));
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int          nb;
        bit          ok;
        logic [7:0]  held;
        q.push_back(v);
        start_op(v.s, v.x, v.y);
        wait_done(nb, ok);
        chk({name, " done seen"}, 64'(ok), 64'(1));
        chk({name, " busy cycles"}, 64'(nb), 64'(8));
        held = out;
        check_result(name);
        // Result must hold through DONE while ack stays low.
        repeat (2) @(negedge clk);
        chk({name, " hold"}, 64'(out), 64'(held));
        chk({name, " still done"}, 64'(done), 64'(1));
        do_ack();
    endtask

    initial begin
        int   nb;
        bit   ok;
        bit   saw_done;
        vec_t v;

        tbl[0] = '{1'b0, 8'h5A, 8'h33, 8'h8D, 1'b0, 1'b1};
        tbl[1] = '{1'b1, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
        tbl[3] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
        tbl[5] = '{1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
        tbl[7] = '{1'b1, 8'h7F, 8'hFF, 8'h80, 1'b0, 1'b1};
        tbl[8] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        tbl[9] = '{1'b1, 8'h05, 8'h03, 8'h02, 1'b1, 1'b0};

        rst = 1'b1; en = 1'b0; sub = 1'b0; a = '0; b = '0; ack = 1'b0;
        en2 = 1'b0; sub2 = 1'b0; a2 = '0; b2 = '0; ack2 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        chk("reset out",  64'(out),  64'(0));
        chk("reset cout", 64'(cout), 64'(0));
        chk("reset ovf",  64'(ovf),  64'(0));
        chk("reset busy", 64'(busy), 64'(0));
        chk("reset done", 64'(done), 64'(0));

        for (int i = 0; i < 10; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 6; i++) begin
            v = model(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
            run_vec(v, $sformatf("rnd%0d", i));
        end

        // Inputs changing during ADD (en, operands, ack) must not disturb it.
        q.push_back(tbl[0]);
        start_op(tbl[0].s, tbl[0].x, tbl[0].y);
        en = 1'b1; sub = 1'b1; a = 8'hFF; b = 8'h77; ack = 1'b1;
        @(negedge clk);
        en = 1'b0; ack = 1'b0; a = 8'h01;
        @(negedge clk);
        en = 1'b1; ack = 1'b1;
        @(negedge clk);
        en = 1'b0; ack = 1'b0;
        wait_done(nb, ok);
        chk("ignore done seen", 64'(ok), 64'(1));
        check_result("ignore");
        do_ack();

        // Reset on the third ADD cycle aborts the operation.
        start_op(1'b1, 8'hA5, 8'h3C);
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort out",  64'(out),  64'(0));
        chk("abort cout", 64'(cout), 64'(0));
        chk("abort ovf",  64'(ovf),  64'(0));
        chk("abort busy", 64'(busy), 64'(0));
        chk("abort done", 64'(done), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        chk("abort no done", 64'(saw_done), 64'(0));
        run_vec(model(1'b1, 8'hA5, 8'h3C), "after abort");

        // en and ack together in DONE: IDLE first, then ADD on held en.
        q.push_back(model(1'b0, 8'h10, 8'h01));
        start_op(1'b0, 8'h10, 8'h01);
        wait_done(nb, ok);
        chk("enack done seen", 64'(ok), 64'(1));
        check_result("enack first");
        en = 1'b1; ack = 1'b1; sub = 1'b0; a = 8'h22; b = 8'h11;
        @(negedge clk);
        ack = 1'b0;
        chk("enack idle busy", 64'(busy), 64'(0));
        chk("enack idle done", 64'(done), 64'(0));
        chk("enack idle out",  64'(out),  64'(8'h11));
        @(negedge clk);
        en = 1'b0;
        chk("enack add busy", 64'(busy), 64'(1));
        q.push_back(model(1'b0, 8'h22, 8'h11));
        wait_done(nb, ok);
        chk("enack second done", 64'(ok), 64'(1));
        check_result("enack second");
        do_ack();

        // Chunked path: WIDTH=16, BPC=4 takes four ADD cycles.
        @(negedge clk);
        en2 = 1'b1; sub2 = 1'b0; a2 = 16'hFFFF; b2 = 16'h0001;
        @(negedge clk);
        en2 = 1'b0;
        nb = 0; ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (done2) begin ok = 1'b1; break; end
            if (busy2) nb++;
            @(negedge clk);
        end
        chk("w16 done seen", 64'(ok), 64'(1));
        chk("w16 busy cycles", 64'(nb), 64'(4));
        chk("w16 out",  64'(out2),  64'(16'h0000));
        chk("w16 cout", 64'(cout2), 64'(1));
        chk("w16 ovf",  64'(ovf2),  64'(0));
        ack2 = 1'b1;
        @(negedge clk);
        ack2 = 1'b0;
        en2 = 1'b1; sub2 = 1'b1; a2 = 16'h8000; b2 = 16'h0001;
        @(negedge clk);
        en2 = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (done2) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk("w16 sub done seen", 64'(ok), 64'(1));
        chk("w16 sub out",  64'(out2),  64'(16'h7FFF));
        chk("w16 sub cout", 64'(cout2), 64'(1));
        chk("w16 sub ovf",  64'(ovf2),  64'(1));

        chk("scoreboard empty", 64'(q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
